// File: rtl/fifo_tx_reader.sv
// Read-side consumer for the show-ahead register-file FIFO: pops one byte per
// frame and shifts it out on tx as 8N1 UART, back-to-back when data is waiting.
module fifo_tx_reader #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rdata,
    output logic       fifo_rd,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             bit_end;

    assign bit_end = (baud_cnt == CNT_LAST);

    // The pop is only legal in IDLE or on the final STOP cycle, which is what
    // lets the next frame start with no idle gap.
    assign fifo_rd = reset & tx_en & ~fifo_empty &
                     ((state == IDLE) | ((state == STOP) & bit_end));
    assign tx_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every branch below sees
            // the pre-edge register values (tx <= shift_reg[1] relies on it).
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (fifo_rd) begin
                        shift_reg <= fifo_rdata;
                        state     <= START;
                        tx        <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx       <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt  <= '0;
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx_done  <= 1'b1;
                        if (fifo_rd) begin
                            shift_reg <= fifo_rdata;
                            state     <= START;
                            tx        <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_tx_reader.sv
// Bench for fifo_tx_reader: a queue stands in for the FIFO, and a frame-position
// model predicts tx, fifo_rd, tx_busy and tx_done every cycle.
module tb_fifo_tx_reader;

    localparam int C     = 4;
    localparam int FRAME = 10 * C;

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       tx_en      = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_rdata = 8'h00;
    logic       fifo_rd;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    fifo_tx_reader #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // FIFO contents, plus pop/push that take effect at the next rising edge
    logic [7:0] q[$];
    logic       pend_pop  = 1'b0;
    logic       pend_push = 1'b0;
    logic [7:0] pend_data = 8'h00;

    // Model: cycles since the frame started (-1 when idle) and its byte
    int         pos      = -1;
    logic [7:0] cur      = 8'h00;
    logic       exp_done = 1'b0;

    int n_rd   = 0;
    int n_busy = 0;
    int n_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame = start bit 0, eight data bits LSB first, stop bit 1
    function automatic logic frame_bit(input logic [7:0] b, input int p);
        int k;
        k = p / C;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic cycle(input logic rst_v, input logic en_v,
                         input logic push_v, input logic [7:0] push_d);
        logic exp_rd;
        logic exp_tx;
        @(negedge clk);
        if (pend_pop && q.size() > 0) void'(q.pop_front());
        if (pend_push && q.size() < 16) q.push_back(pend_data);
        reset      = rst_v;
        tx_en      = en_v;
        fifo_empty = (q.size() == 0);
        fifo_rdata = (q.size() == 0) ? 8'($urandom) : q[0];
        #1;
        exp_rd = rst_v && en_v && (q.size() != 0) && (pos < 0 || pos == FRAME - 1);
        exp_tx = (pos < 0) ? 1'b1 : frame_bit(cur, pos);
        check("fifo_rd", 32'(fifo_rd), 32'(exp_rd));
        check("tx", 32'(tx), 32'(exp_tx));
        check("tx_busy", 32'(tx_busy), 32'(pos >= 0));
        check("tx_done", 32'(tx_done), 32'(exp_done));
        n_rd   += int'(fifo_rd);
        n_busy += int'(tx_busy);
        n_done += int'(tx_done);
        pend_pop  = fifo_rd;
        pend_push = push_v;
        pend_data = push_d;
        if (!rst_v) begin
            pos      = -1;
            exp_done = 1'b0;
        end else begin
            exp_done = (pos == FRAME - 1);
            if (exp_rd) begin
                pos = 0;
                cur = q[0];
            end else if (pos == FRAME - 1) begin
                pos = -1;
            end else if (pos >= 0) begin
                pos++;
            end
        end
    endtask

    task automatic run(input logic en_v, input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, en_v, 1'b0, 8'h00);
    endtask

    task automatic clear_counts();
        n_rd   = 0;
        n_busy = 0;
        n_done = 0;
    endtask

    initial begin
        logic en_r;
        q.push_back(8'hA5);

        // Reset hold with data available and enable high
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("reset_no_pop", 32'(q.size()), 32'd1);

        // Single byte 0xA5
        clear_counts();
        run(1'b1, 50);
        check("single_rd_count", 32'(n_rd), 32'd1);
        check("single_busy_cycles", 32'(n_busy), 32'd40);
        check("single_done_count", 32'(n_done), 32'd1);
        check("single_fifo_empty", 32'(q.size()), 32'd0);

        // Back-to-back 0x00 then 0xFF
        clear_counts();
        cycle(1'b1, 1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b0, 1'b1, 8'hFF);
        run(1'b1, 90);
        check("b2b_rd_count", 32'(n_rd), 32'd2);
        check("b2b_busy_cycles", 32'(n_busy), 32'd80);
        check("b2b_done_count", 32'(n_done), 32'd2);

        // Enable gating: three bytes held, then enable dropped mid-DATA
        clear_counts();
        cycle(1'b1, 1'b0, 1'b1, 8'h11);
        cycle(1'b1, 1'b0, 1'b1, 8'h22);
        cycle(1'b1, 1'b0, 1'b1, 8'h33);
        run(1'b0, 50);
        check("gate_no_rd", 32'(n_rd), 32'd0);
        run(1'b1, 15);
        run(1'b0, 60);
        check("gate_rd_count", 32'(n_rd), 32'd1);
        check("gate_remaining", 32'(q.size()), 32'd2);
        run(1'b1, 100);
        check("gate_drained", 32'(q.size()), 32'd0);

        // Empty boundary
        clear_counts();
        run(1'b1, 100);
        check("empty_no_rd", 32'(n_rd), 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 8'h5A);
        run(1'b1, 50);
        check("empty_rd_count", 32'(n_rd), 32'd1);

        // Reset during bit 3 of 0x3C
        clear_counts();
        cycle(1'b1, 1'b1, 1'b1, 8'h3C);
        run(1'b1, 18);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        run(1'b1, 20);
        check("rst_mid_rd_count", 32'(n_rd), 32'd1);
        check("rst_mid_no_done", 32'(n_done), 32'd0);
        check("rst_mid_no_replay", 32'(q.size()), 32'd0);

        // Randomised traffic, enable toggling and occasional resets
        en_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic rst_v;
            logic push_v;
            if ($urandom_range(0, 59) == 0) en_r = ~en_r;
            rst_v  = ($urandom_range(0, 699) != 0);
            push_v = ($urandom_range(0, 29) == 0) && (q.size() < 15);
            cycle(rst_v, en_r, push_v, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_tx_reader.md
Name: fifo_tx_reader

Overview:
Read-side consumer for the 16x8 register-file FIFO. It pops bytes through the FIFO's rd/empty/r_data port and serialises each byte as an 8N1 UART frame on a single tx line. It sits between the FIFO read port and the board TX pin. The FIFO's r_data is show-ahead, meaning it is combinationally valid whenever empty=0, so a byte is sampled in the same cycle rd is asserted.

Parameters:
CLKS_PER_BIT, 10417, clock cycles per UART bit (100 MHz / 9600 baud); legal range >= 2
CNT_W, $clog2(CLKS_PER_BIT), width of the baud counter; derived, not overridden

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset (asserted when 0)
tx_en  in  1  permission to start new frames
fifo_empty  in  1  FIFO empty flag
fifo_rdata  in  8  FIFO head byte, valid when fifo_empty=0
fifo_rd  out  1  pop strobe to FIFO, combinational, one cycle per byte
tx  out  1  serial output, registered, idle high
tx_busy  out  1  high while a frame is in progress (state != IDLE)
tx_done  out  1  one-cycle pulse after each frame's stop bit

Behaviour:
- Reset (reset=0 at a rising edge): state=IDLE, tx=1, tx_busy=0, tx_done=0, counters=0, shift reg=0. fifo_rd=0 whenever reset=0.
- States: IDLE, START, DATA, STOP. Baud counter runs 0..CLKS_PER_BIT-1. Bit index is 3 bits.
- IDLE:
  - fifo_rd = tx_en & ~fifo_empty.
  - When fifo_rd=1: latch fifo_rdata into the shift reg, go to START, set tx<=0, clear the baud counter.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA:
  - tx = shift[0] (LSB first), each bit held CLKS_PER_BIT cycles.
  - Shift right at the end of each bit.
  - After bit 7, go to STOP with tx=1.
- STOP: tx=1 for CLKS_PER_BIT cycles. On the last STOP cycle:
  - If tx_en & ~fifo_empty: fifo_rd=1 in that cycle, latch the new byte, go directly to START. Back-to-back frames have no idle gap.
  - Else go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles, measured from the edge that samples fifo_rd=1.
- tx_done is registered: it is 1 for exactly one cycle, the cycle after the last STOP cycle. This holds for both the back-to-back and the IDLE exit.
- fifo_rd is never asserted when fifo_empty=1. It is never asserted in START or DATA, or in non-final STOP cycles. At most one pop per frame.
- fifo_rdata is sampled only in a cycle where fifo_rd=1. Its value at all other times is ignored.
- tx_en deasserted mid-frame: the current frame completes unchanged and no further pop occurs. tx_en is checked only in IDLE and on the last STOP cycle.
- Reset mid-frame: at the next edge tx=1 and state=IDLE. The popped byte is discarded and is not re-read.
- The baud counter wraps only through explicit clear. There is no free-running prescaler, so the frame phase is set by the pop edge.

Test Plan:
1. Reset hold: CLKS_PER_BIT=4, reset=0 for 3 cycles with tx_en=1, fifo_empty=0 -> tx=1, fifo_rd=0, tx_busy=0, tx_done=0 on every cycle.
2. Single byte: CLKS_PER_BIT=4, FIFO holds 0xA5, tx_en=1 -> exactly one fifo_rd pulse. tx emits 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles. tx_busy is high for 40 cycles. tx_done pulses once at cycle 41. fifo_empty=1 afterwards.
3. Back-to-back with a real fifo instance: write 0x00 then 0xFF -> the second fifo_rd occurs on the last STOP cycle of frame 1. There are 80 contiguous busy cycles with no idle-high gap. tx_done pulses at cycles 41 and 81. The bytes decode as 0x00 then 0xFF.
4. Enable gating: FIFO holds 3 bytes, tx_en=0 for 50 cycles -> no fifo_rd and tx=1 throughout. Raise tx_en, then drop it during frame 1's DATA -> frame 1 completes, no second pop occurs, and 2 bytes remain.
5. Empty boundary: tx_en=1, fifo_empty=1 for 100 cycles -> fifo_rd stays 0. Push one byte -> the pop occurs on the next cycle. After the frame the block returns to IDLE with tx=1.
6. Reset mid-DATA: reset=0 for 1 cycle at bit 3 of 0x3C -> tx=1 and tx_busy=0 on the next cycle, with no tx_done pulse. The FIFO read pointer stays advanced by 1, so the byte is not replayed.
